// File: rtl/receiver_if.sv
// GMII receive bus and RX frame-slot memory port of the frame receiver.
// The master modport is the receiver; the slave modport is the PHY/memory side.
interface receiver_if;
    logic [7:0]  gmii_rxd;
    logic        gmii_rx_dv;
    logic        gmii_rx_er;
    logic [15:0] slot_rx_eth_data;
    logic [1:0]  slot_rx_eth_byte_en;
    logic [13:0] slot_rx_eth_addr;
    logic        slot_rx_eth_wr_en;
    logic [13:0] mem_rd_ptr;
    logic [13:0] mem_wr_ptr;

    modport master (
        input  gmii_rxd, gmii_rx_dv, gmii_rx_er, mem_rd_ptr,
        output slot_rx_eth_data, slot_rx_eth_byte_en, slot_rx_eth_addr,
        output slot_rx_eth_wr_en, mem_wr_ptr
    );

    modport slave (
        output gmii_rxd, gmii_rx_dv, gmii_rx_er, mem_rd_ptr,
        input  slot_rx_eth_data, slot_rx_eth_byte_en, slot_rx_eth_addr,
        input  slot_rx_eth_wr_en, mem_wr_ptr
    );
endinterface

// File: rtl/receiver.sv
// GMII frame receiver: strips preamble/SFD and stores each frame as a slot record
// (7 header words + big-endian data) in a 16-bit ring. Define RX_FCS_CHECK_EN to drop bad-FCS frames.
module receiver (
    input  logic        gmii_rx_clk,
    input  logic        sys_rst_n,
    input  logic [63:0] global_counter,
    receiver_if.master  rx_if,
    output logic [31:0] rx_frame_count,
    output logic [31:0] rx_drop_count
);
    localparam logic [7:0]  SFD       = 8'hD5;
    localparam logic [11:0] MIN_BYTES = 12'd64;
    localparam logic [11:0] MAX_BYTES = 12'd2048;

    typedef enum logic [2:0] {
        RX_IDLE     = 3'd0,
        RX_PREAMBLE = 3'd1,
        RX_DATA     = 3'd2,
        RX_HDR      = 3'd3,
        RX_DROP     = 3'd4
    } rx_state_t;

    rx_state_t   state_r;
    logic        armed_r;
    logic [13:0] base_r;
    logic [63:0] ts_r;
    logic [11:0] byte_cnt_r;
    logic [7:0]  hold_r;
    logic [31:0] fcs_sh_r;
    logic [2:0]  hdr_idx_r;

    logic [15:0] data_r;
    logic [1:0]  be_r;
    logic [13:0] addr_r;
    logic        wr_en_r;
    logic [13:0] wr_ptr_r;
    logic [31:0] frame_cnt_r;
    logic [31:0] drop_cnt_r;

    logic [11:0] cnt_inc_s;
    logic [13:0] rd_lim_s;
    logic [13:0] word_addr_s;
    logic [13:0] commit_ptr_s;
    logic [13:0] hdr_off_s;
    logic        hdr_clash_s;
    logic        pair_full_s;
    logic        fcs_bad_s;
    logic        drop_s;
    logic [15:0] hdr_word_s;

`ifdef RX_FCS_CHECK_EN
    // Reflected CRC register residue; this is the bit-reversed form of C704DD7B.
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    logic [31:0] crc_r;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) begin
                c = (c >> 1) ^ 32'hEDB88320;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    // FCS is good when the CRC over data plus FCS leaves the fixed residue.
    always_comb begin
        fcs_bad_s = (crc_r != CRC_RESIDUE);
    end
`else
    assign fcs_bad_s = 1'b0;
`endif

    assign rx_if.slot_rx_eth_data    = data_r;
    assign rx_if.slot_rx_eth_byte_en = be_r;
    assign rx_if.slot_rx_eth_addr    = addr_r;
    assign rx_if.slot_rx_eth_wr_en   = wr_en_r;
    assign rx_if.mem_wr_ptr          = wr_ptr_r;
    assign rx_frame_count            = frame_cnt_r;
    assign rx_drop_count             = drop_cnt_r;

    // Address arithmetic; the ring is full when a write would land on mem_rd_ptr-1.
    always_comb begin
        cnt_inc_s    = byte_cnt_r + 12'd1;
        rd_lim_s     = rx_if.mem_rd_ptr - 14'd1;
        word_addr_s  = base_r + 14'd7 + {3'b000, byte_cnt_r[11:1]};
        commit_ptr_s = base_r + 14'd7 + {2'b00, cnt_inc_s[11:1]};
        hdr_off_s    = rd_lim_s - base_r;
        hdr_clash_s  = (hdr_off_s < 14'd7);
        pair_full_s  = byte_cnt_r[0] && (word_addr_s == rd_lim_s);
    end

    // Drop decision for the current RX_DATA cycle (mid-frame or at dv fall).
    always_comb begin
        drop_s = 1'b0;
        if (state_r == RX_DATA) begin
            if (rx_if.gmii_rx_er) begin
                drop_s = 1'b1;
            end else if (rx_if.gmii_rx_dv) begin
                drop_s = (cnt_inc_s > MAX_BYTES) || pair_full_s;
            end else begin
                drop_s = (byte_cnt_r < MIN_BYTES) || fcs_bad_s || hdr_clash_s || pair_full_s;
            end
        end else begin
            drop_s = 1'b0;
        end
    end

    // Header word selected by the header write index.
    always_comb begin
        hdr_word_s = 16'h0000;
        case (hdr_idx_r)
            3'd0:    hdr_word_s = {4'h0, byte_cnt_r} - 16'd4;
            3'd1:    hdr_word_s = ts_r[63:48];
            3'd2:    hdr_word_s = ts_r[47:32];
            3'd3:    hdr_word_s = ts_r[31:16];
            3'd4:    hdr_word_s = ts_r[15:0];
            3'd5:    hdr_word_s = fcs_sh_r[31:16];
            3'd6:    hdr_word_s = fcs_sh_r[15:0];
            default: hdr_word_s = 16'h0000;
        endcase
    end

    // Receive FSM with registered slot write port, pointer and counters.
    always_ff @(posedge gmii_rx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r     <= RX_IDLE;
            armed_r     <= 1'b0;
            base_r      <= 14'd0;
            ts_r        <= 64'd0;
            byte_cnt_r  <= 12'd0;
            hold_r      <= 8'd0;
            fcs_sh_r    <= 32'd0;
            hdr_idx_r   <= 3'd0;
            data_r      <= 16'd0;
            be_r        <= 2'b00;
            addr_r      <= 14'd0;
            wr_en_r     <= 1'b0;
            wr_ptr_r    <= 14'd0;
            frame_cnt_r <= 32'd0;
            drop_cnt_r  <= 32'd0;
`ifdef RX_FCS_CHECK_EN
            crc_r       <= 32'hFFFFFFFF;
`endif
        end else begin
            wr_en_r <= 1'b0;
            // A frame in flight at reset release is ignored until the line goes idle.
            if (!rx_if.gmii_rx_dv) begin
                armed_r <= 1'b1;
            end
            case (state_r)
                RX_IDLE: begin
                    if (rx_if.gmii_rx_dv && armed_r) begin
                        state_r <= RX_PREAMBLE;
                    end
                end
                RX_PREAMBLE: begin
                    if (!rx_if.gmii_rx_dv) begin
                        state_r <= RX_IDLE;
                    end else if (rx_if.gmii_rxd == SFD) begin
                        ts_r       <= global_counter;
                        base_r     <= wr_ptr_r;
                        byte_cnt_r <= 12'd0;
`ifdef RX_FCS_CHECK_EN
                        crc_r      <= 32'hFFFFFFFF;
`endif
                        state_r    <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (drop_s) begin
                        drop_cnt_r <= drop_cnt_r + 32'd1;
                        state_r    <= RX_DROP;
                    end else if (rx_if.gmii_rx_dv) begin
                        byte_cnt_r <= cnt_inc_s;
                        hold_r     <= rx_if.gmii_rxd;
                        fcs_sh_r   <= {fcs_sh_r[23:0], rx_if.gmii_rxd};
`ifdef RX_FCS_CHECK_EN
                        crc_r      <= crc32_byte(crc_r, rx_if.gmii_rxd);
`endif
                        if (byte_cnt_r[0]) begin
                            wr_en_r <= 1'b1;
                            be_r    <= 2'b11;
                            addr_r  <= word_addr_s;
                            data_r  <= {hold_r, rx_if.gmii_rxd};
                        end
                    end else begin
                        if (byte_cnt_r[0]) begin
                            wr_en_r <= 1'b1;
                            be_r    <= 2'b10;
                            addr_r  <= word_addr_s;
                            data_r  <= {hold_r, 8'h00};
                        end
                        hdr_idx_r <= 3'd0;
                        state_r   <= RX_HDR;
                    end
                end
                RX_HDR: begin
                    wr_en_r <= 1'b1;
                    be_r    <= 2'b11;
                    addr_r  <= base_r + {11'd0, hdr_idx_r};
                    data_r  <= hdr_word_s;
                    if (hdr_idx_r == 3'd6) begin
                        wr_ptr_r    <= commit_ptr_s;
                        frame_cnt_r <= frame_cnt_r + 32'd1;
                        state_r     <= rx_if.gmii_rx_dv ? RX_PREAMBLE : RX_IDLE;
                    end else begin
                        hdr_idx_r <= hdr_idx_r + 3'd1;
                    end
                end
                RX_DROP: begin
                    if (!rx_if.gmii_rx_dv) begin
                        state_r <= RX_IDLE;
                    end
                end
                default: begin
                    state_r <= RX_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_receiver.sv
// Self-checking bench for receiver: table vectors, random frames against a slot-record model,
// and hand sequences for back-to-back frames, mid-frame reset and ring wrap.
`timescale 1ns/1ps
module tb_receiver;
    typedef logic [7:0] byte_q_t [$];
    typedef struct {
        int n;
        int er_at;
        bit bad;
        int rd_rel;
        int adv;
    } vec_t;

`ifdef RX_FCS_CHECK_EN
    localparam bit FCS_ON  = 1'b1;
    localparam int FCS_ADV = 0;
`else
    localparam bit FCS_ON  = 1'b0;
    localparam int FCS_ADV = 39;
`endif

    logic        gmii_rx_clk = 1'b0;
    logic        sys_rst_n;
    logic [63:0] global_counter;
    logic [31:0] rx_frame_count;
    logic [31:0] rx_drop_count;

    receiver_if rx_if();

    receiver dut (
        .gmii_rx_clk    (gmii_rx_clk),
        .sys_rst_n      (sys_rst_n),
        .global_counter (global_counter),
        .rx_if          (rx_if),
        .rx_frame_count (rx_frame_count),
        .rx_drop_count  (rx_drop_count)
    );

    always #5 gmii_rx_clk = ~gmii_rx_clk;

    int n_checks = 0;
    int n_errors = 0;
    int exp_wr = 0;
    int exp_frames = 0;
    int exp_drops = 0;

    logic [15:0] mem [0:16383];
    logic [1:0]  mem_be [0:16383];
    int          wr_count = 0;

    // Memory model of the slot RAM, sampled on the falling edge.
    always @(negedge gmii_rx_clk) begin
        if (rx_if.slot_rx_eth_wr_en === 1'b1) begin
            if (rx_if.slot_rx_eth_byte_en[1]) mem[rx_if.slot_rx_eth_addr][15:8] <= rx_if.slot_rx_eth_data[15:8];
            if (rx_if.slot_rx_eth_byte_en[0]) mem[rx_if.slot_rx_eth_addr][7:0] <= rx_if.slot_rx_eth_data[7:0];
            mem_be[rx_if.slot_rx_eth_addr] <= rx_if.slot_rx_eth_byte_en;
            wr_count <= wr_count + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h000000, b};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // n bytes total: n-4 random data bytes plus FCS (optionally corrupted).
    function automatic byte_q_t make_frame(input int n, input bit bad);
        byte_q_t q;
        logic [31:0] c;
        logic [7:0] b;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n - 4; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            c = crc_step(c, b);
        end
        c = ~c;
        if (bad) c = c ^ 32'h00000100;
        q.push_back(c[7:0]);
        q.push_back(c[15:8]);
        q.push_back(c[23:16]);
        q.push_back(c[31:24]);
        return q;
    endfunction

    // Expected pointer advance: 0 means the frame must be dropped.
    function automatic int predict_adv(input int n, input int er_at, input bit bad, input int base, input int rd);
        int words;
        words = 7 + (n + 1) / 2;
        if (er_at >= 0 || n < 64 || n > 2048 || (bad && FCS_ON)) return 0;
        for (int k = 0; k < words; k++) begin
            if ((base + k) % 16384 == (rd + 16383) % 16384) return 0;
        end
        return words;
    endfunction

    task automatic step(input logic dv, input logic er, input logic [7:0] d);
        @(posedge gmii_rx_clk);
        #1;
        rx_if.gmii_rx_dv = dv;
        rx_if.gmii_rx_er = er;
        rx_if.gmii_rxd   = d;
        global_counter   = global_counter + 64'd1;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_frame(input byte_q_t q, input int er_at, output logic [63:0] ts);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'h55);
        step(1'b1, 1'b0, 8'hD5);
        ts = global_counter;
        for (int i = 0; i < q.size(); i++) step(1'b1, (i == er_at), q[i]);
        step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic check_content(input string tag, input int base, input byte_q_t q, input logic [63:0] ts);
        int n, words, bad, first, a, i;
        logic [15:0] ew, mask;
        logic [1:0] ebe;
        n = q.size();
        words = 7 + (n + 1) / 2;
        bad = 0;
        first = -1;
        for (int k = 0; k < words; k++) begin
            a = (base + k) % 16384;
            mask = 16'hFFFF;
            ebe = 2'b11;
            if (k == 0) ew = 16'(n - 4);
            else if (k <= 4) ew = ts[16 * (4 - k) +: 16];
            else if (k == 5) ew = {q[n - 4], q[n - 3]};
            else if (k == 6) ew = {q[n - 2], q[n - 1]};
            else begin
                i = 2 * (k - 7);
                if (i + 1 < n) ew = {q[i], q[i + 1]};
                else begin
                    ew = {q[i], 8'h00};
                    mask = 16'hFF00;
                    ebe = 2'b10;
                end
            end
            if (((mem[a] & mask) !== (ew & mask)) || (mem_be[a] !== ebe)) begin
                bad++;
                if (first < 0) first = a;
            end
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL %s content: %0d bad words (first at %h), expected 0", tag, bad, first);
        end
    endtask

    task automatic check_counts(input string tag);
        check({tag, " wr_ptr"}, 64'(rx_if.mem_wr_ptr), 64'(exp_wr));
        check({tag, " frames"}, 64'(rx_frame_count), 64'(exp_frames));
        check({tag, " drops"}, 64'(rx_drop_count), 64'(exp_drops));
    endtask

    task automatic run_vec(input string tag, input int n, input int er_at, input bit bad, input int rd, input int adv);
        byte_q_t q;
        logic [63:0] ts;
        int base, wc0;
        base = exp_wr;
        rx_if.mem_rd_ptr = 14'(rd);
        q = make_frame(n, bad);
        wc0 = wr_count;
        send_frame(q, er_at, ts);
        idle(12);
        if (adv != 0) begin
            exp_wr = (base + adv) % 16384;
            exp_frames++;
        end else begin
            exp_drops++;
        end
        check_counts(tag);
        if (adv != 0) begin
            check({tag, " writes"}, 64'(wr_count - wc0), 64'(adv));
            check_content(tag, base, q, ts);
        end
    endtask

    vec_t vecs[12];

    initial begin
        byte_q_t qa, qb;
        logic [63:0] tsa, tsb;
        int base, wc0, n, er_at, rd, rem, w;
        bit bad;

        vecs[0]  = '{64,   -1, 1'b0, 0,  39};
        vecs[1]  = '{65,   -1, 1'b0, 0,  40};
        vecs[2]  = '{40,   -1, 1'b0, 0,  0};
        vecs[3]  = '{63,   -1, 1'b0, 0,  0};
        vecs[4]  = '{64,   20, 1'b0, 0,  0};
        vecs[5]  = '{64,   63, 1'b0, 0,  0};
        vecs[6]  = '{64,   -1, 1'b1, 0,  FCS_ADV};
        vecs[7]  = '{2048, -1, 1'b0, 0,  1031};
        vecs[8]  = '{2049, -1, 1'b0, 0,  0};
        vecs[9]  = '{128,  -1, 1'b0, 30, 0};
        vecs[10] = '{128,  -1, 1'b0, 4,  0};
        vecs[11] = '{66,   -1, 1'b0, 41, 40};

        sys_rst_n = 1'b0;
        rx_if.gmii_rxd = 8'h00;
        rx_if.gmii_rx_dv = 1'b0;
        rx_if.gmii_rx_er = 1'b0;
        rx_if.mem_rd_ptr = 14'd0;
        global_counter = 64'h0123_4567_89AB_CDE0;
        repeat (3) @(posedge gmii_rx_clk);
        #1;
        check("reset wr_en", 64'(rx_if.slot_rx_eth_wr_en), 64'd0);
        check_counts("reset");
        sys_rst_n = 1'b1;
        idle(3);

        for (int v = 0; v < 12; v++) begin
            run_vec($sformatf("vec%0d", v), vecs[v].n, vecs[v].er_at, vecs[v].bad,
                    (exp_wr + vecs[v].rd_rel) % 16384, vecs[v].adv);
        end

        // Back-to-back frames: second preamble starts one cycle after dv falls.
        base = exp_wr;
        rx_if.mem_rd_ptr = 14'(base);
        qa = make_frame(64, 1'b0);
        qb = make_frame(70, 1'b0);
        wc0 = wr_count;
        send_frame(qa, -1, tsa);
        send_frame(qb, -1, tsb);
        idle(12);
        exp_wr = (base + 39 + 42) % 16384;
        exp_frames += 2;
        check_counts("b2b");
        check("b2b writes", 64'(wr_count - wc0), 64'd81);
        check_content("b2b A", base, qa, tsa);
        check_content("b2b B", (base + 39) % 16384, qb, tsb);

        for (int r = 0; r < 24; r++) begin
            n = $urandom_range(40, 300);
            er_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, n - 1) : -1;
            bad = ($urandom_range(0, 5) == 0);
            rd = ($urandom_range(0, 5) == 0) ? (exp_wr + $urandom_range(1, 200)) % 16384 : exp_wr;
            run_vec($sformatf("rand%0d", r), n, er_at, bad, rd, predict_adv(n, er_at, bad, exp_wr, rd));
        end

        // Reset at data byte 30, release while the old frame is still on the line.
        qa = make_frame(120, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'h55);
        step(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0, qa[i]);
        sys_rst_n = 1'b0;
        #1;
        check("rst data", 64'(rx_if.slot_rx_eth_data), 64'd0);
        check("rst be", 64'(rx_if.slot_rx_eth_byte_en), 64'd0);
        check("rst addr", 64'(rx_if.slot_rx_eth_addr), 64'd0);
        check("rst wr_en", 64'(rx_if.slot_rx_eth_wr_en), 64'd0);
        exp_wr = 0;
        exp_frames = 0;
        exp_drops = 0;
        check_counts("rst");
        step(1'b1, 1'b0, qa[30]);
        sys_rst_n = 1'b1;
        for (int i = 31; i < 50; i++) step(1'b1, 1'b0, qa[i]);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'h55);
        step(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 70; i++) step(1'b1, 1'b0, 8'(i));
        idle(12);
        check_counts("post-rst");
        run_vec("after rst", 64, -1, 1'b0, 0, 39);

        // Advance the pointer to 3FF0, then a frame that wraps past 3FFF.
        rem = (16'h3FF0 - exp_wr + 16384) % 16384;
        while (rem > 2062) begin
            run_vec("fill", 2048, -1, 1'b0, exp_wr, 1031);
            rem -= 1031;
        end
        w = rem / 2;
        run_vec("fill", 2 * (w - 7), -1, 1'b0, exp_wr, w);
        w = rem - w;
        run_vec("fill", 2 * (w - 7), -1, 1'b0, exp_wr, w);
        check("pre-wrap wr_ptr", 64'(rx_if.mem_wr_ptr), 64'h3FF0);
        run_vec("wrap", 100, -1, 1'b0, 16'h0100, predict_adv(100, -1, 1'b0, exp_wr, 16'h0100));
        check("wrap wr_ptr", 64'(rx_if.mem_wr_ptr), 64'h0029);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
